fifo_param: RTL and testbench

Parametrised synchronous FIFO: the next generation of the team's 4-entry 8-bit FIFO, generalised to any data width and power-of-two depth. It adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous clear. It sits between a producer and a consumer in the same clock domain, for example UART RX/TX buffering or a CPU peripheral queue. Read data is show-ahead: the head entry is always visible on `rdata`.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ram.sv | 27 ++
 rtl/fifo_param.sv | 127 ++++++++++++
 tb/tb_fifo_param.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    // Request encoding is {wr_en, rd_en}.
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        READ       = 2'b01,
        WRITE      = 2'b10,
        READ_WRITE = 2'b11
    } fifo_op_e;

    function automatic int fifo_depth(input int addr_width);
        return 32'sd1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read, no reset on storage.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [fifo_depth(ADDR_WIDTH)];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised show-ahead synchronous FIFO with occupancy, programmable
// threshold flags, sticky error flags and synchronous clear.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE_C = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_LVL_C  = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_LVL_C  = AE_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wr_accept_s;
    fifo_op_e            op_s;

    // Status is a pure function of the registered pointers.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == {(ADDR_WIDTH+1){1'b0}});
    assign almost_full  = (count >= AF_LVL_C);
    assign almost_empty = (count <= AE_LVL_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign op_s         = fifo_op_e'({wr_en, rd_en});

    // Next-state for pointers and sticky error flags; clear overrides requests.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_accept_s = 1'b0;
        if (clear) begin
            wr_ptr_d    = {(ADDR_WIDTH+1){1'b0}};
            rd_ptr_d    = {(ADDR_WIDTH+1){1'b0}};
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            case (op_s)
                IDLE: begin
                    wr_ptr_d = wr_ptr_q;
                end
                READ: begin
                    if (!empty) rd_ptr_d = rd_ptr_q + PTR_ONE_C;
                    else        underflow_d = 1'b1;
                end
                WRITE: begin
                    if (!full) begin
                        wr_accept_s = 1'b1;
                        wr_ptr_d    = wr_ptr_q + PTR_ONE_C;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                READ_WRITE: begin
                    // DEPTH >= 2, so empty and full are mutually exclusive.
                    if (empty) begin
                        wr_accept_s = 1'b1;
                        wr_ptr_d    = wr_ptr_q + PTR_ONE_C;
                        underflow_d = 1'b1;
                    end else if (full) begin
                        rd_ptr_d   = rd_ptr_q + PTR_ONE_C;
                        overflow_d = 1'b1;
                    end else begin
                        wr_accept_s = 1'b1;
                        wr_ptr_d    = wr_ptr_q + PTR_ONE_C;
                        rd_ptr_d    = rd_ptr_q + PTR_ONE_C;
                    end
                end
                default: begin
                    wr_ptr_d = wr_ptr_q;
                end
            endcase
        end
    end

    // Pointer and error-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= {(ADDR_WIDTH+1){1'b0}};
            rd_ptr_q    <= {(ADDR_WIDTH+1){1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept_s),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fifo_param.sv
// Directed vector bench for fifo_param: a 4x8 instance driven from a table
// plus hand sequences for async reset and a 16x16 instance.
module tb_fifo_param;

    typedef struct {
        logic       clr, wr, rd;
        logic [7:0] wd;
        logic [2:0] cnt;
        logic       emp, ful, af, ae, ov, un, chk_rd;
        logic [7:0] rd_exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, clear, wr_en, rd_en;
    logic [7:0] wdata, rdata;
    logic       full, almost_full, empty, almost_empty, overflow, underflow;
    logic [2:0] count;

    logic        reset_b, clear_b, wr_en_b, rd_en_b;
    logic [15:0] wdata_b, rdata_b;
    logic        full_b, almost_full_b, empty_b, almost_empty_b, overflow_b, underflow_b;
    logic [4:0]  count_b;

    int   n_vec  = 0;
    int   n_fail = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk(clk), .reset(reset), .clear(clear), .wdata(wdata), .wr_en(wr_en),
        .full(full), .almost_full(almost_full), .rdata(rdata), .rd_en(rd_en),
        .empty(empty), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset_b), .clear(clear_b), .wdata(wdata_b), .wr_en(wr_en_b),
        .full(full_b), .almost_full(almost_full_b), .rdata(rdata_b), .rd_en(rd_en_b),
        .empty(empty_b), .almost_empty(almost_empty_b), .count(count_b),
        .overflow(overflow_b), .underflow(underflow_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic addv(input logic clr, input logic wr, input logic rd, input logic [7:0] wd,
                        input logic [2:0] cnt, input logic emp, input logic ful,
                        input logic af, input logic ae, input logic ov, input logic un,
                        input logic chk_rd, input logic [7:0] rd_exp);
        vec_t v;
        v.clr = clr; v.wr = wr; v.rd = rd; v.wd = wd; v.cnt = cnt; v.emp = emp;
        v.ful = ful; v.af = af; v.ae = ae; v.ov = ov; v.un = un;
        v.chk_rd = chk_rd; v.rd_exp = rd_exp;
        vq.push_back(v);
    endtask

    task automatic chk_small(input string tag, input logic [2:0] cnt, input logic emp,
                             input logic ful, input logic af, input logic ae,
                             input logic ov, input logic un);
        chk({tag, ".count"},        {29'd0, count},        {29'd0, cnt});
        chk({tag, ".empty"},        {31'd0, empty},        {31'd0, emp});
        chk({tag, ".full"},         {31'd0, full},         {31'd0, ful});
        chk({tag, ".almost_full"},  {31'd0, almost_full},  {31'd0, af});
        chk({tag, ".almost_empty"}, {31'd0, almost_empty}, {31'd0, ae});
        chk({tag, ".overflow"},     {31'd0, overflow},     {31'd0, ov});
        chk({tag, ".underflow"},    {31'd0, underflow},    {31'd0, un});
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
        reset_b = 1'b1; clear_b = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0; wdata_b = 16'h0000;

        // 1: fill then drain
        addv(0,1,0,8'h11, 1,0,0,0,1,0,0, 1,8'h11);
        addv(0,1,0,8'h22, 2,0,0,0,0,0,0, 1,8'h11);
        addv(0,1,0,8'h33, 3,0,0,1,0,0,0, 1,8'h11);
        addv(0,1,0,8'h44, 4,0,1,1,0,0,0, 1,8'h11);
        addv(0,0,1,8'h00, 3,0,0,1,0,0,0, 1,8'h22);
        addv(0,0,1,8'h00, 2,0,0,0,0,0,0, 1,8'h33);
        addv(0,0,1,8'h00, 1,0,0,0,1,0,0, 1,8'h44);
        addv(0,0,1,8'h00, 0,1,0,0,1,0,0, 0,8'h00);
        // 2: overflow on full, data dropped
        addv(0,1,0,8'h11, 1,0,0,0,1,0,0, 1,8'h11);
        addv(0,1,0,8'h22, 2,0,0,0,0,0,0, 1,8'h11);
        addv(0,1,0,8'h33, 3,0,0,1,0,0,0, 1,8'h11);
        addv(0,1,0,8'h44, 4,0,1,1,0,0,0, 1,8'h11);
        addv(0,1,0,8'h55, 4,0,1,1,0,1,0, 1,8'h11);
        addv(0,0,0,8'h00, 4,0,1,1,0,1,0, 1,8'h11);
        addv(0,0,1,8'h00, 3,0,0,1,0,1,0, 1,8'h22);
        addv(0,0,1,8'h00, 2,0,0,0,0,1,0, 1,8'h33);
        addv(0,0,1,8'h00, 1,0,0,0,1,1,0, 1,8'h44);
        addv(0,0,1,8'h00, 0,1,0,0,1,1,0, 0,8'h00);
        // 3: simultaneous read/write on empty
        addv(0,1,1,8'hA5, 1,0,0,0,1,1,1, 1,8'hA5);
        addv(0,0,1,8'h00, 0,1,0,0,1,1,1, 0,8'h00);
        // 4: count 2, ten read+write cycles across the pointer wrap
        addv(0,1,0,8'hE0, 1,0,0,0,1,1,1, 1,8'hE0);
        addv(0,1,0,8'hE1, 2,0,0,0,0,1,1, 1,8'hE0);
        for (int k = 0; k < 10; k++) begin
            addv(0,1,1,8'(k), 2,0,0,0,0,1,1, 1, (k == 0) ? 8'hE1 : 8'(k - 1));
        end
        // 5: clear beats a write at count 3 with overflow set
        addv(0,1,0,8'h77, 3,0,0,1,0,1,1, 1,8'h08);
        addv(1,1,0,8'h99, 0,1,0,0,1,0,0, 0,8'h00);
        addv(0,0,0,8'h00, 0,1,0,0,1,0,0, 0,8'h00);
        addv(0,1,0,8'hC3, 1,0,0,0,1,0,0, 1,8'hC3);
        addv(1,1,1,8'h5A, 0,1,0,0,1,0,0, 0,8'h00);

        #12;
        chk_small("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            clear = vq[i].clr; wr_en = vq[i].wr; rd_en = vq[i].rd; wdata = vq[i].wd;
            @(posedge clk);
            #1;
            chk_small($sformatf("v%0d", i), vq[i].cnt, vq[i].emp, vq[i].ful,
                      vq[i].af, vq[i].ae, vq[i].ov, vq[i].un);
            if (vq[i].chk_rd) chk($sformatf("v%0d.rdata", i), {24'd0, rdata}, {24'd0, vq[i].rd_exp});
        end

        // 6a: asynchronous reset between edges, with overflow pending
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear = 1'b0; wr_en = 1'b1; rd_en = 1'b0; wdata = 8'(8'hB0 + i);
        end
        @(posedge clk);
        #1;
        chk("pre_areset.overflow", {31'd0, overflow}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_small("areset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b0;

        // 6b: 16x16 fill and drain
        reset_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en_b = 1'b1; wdata_b = 16'(16'hA000 + i);
            @(posedge clk);
            #1;
            chk($sformatf("b_w%0d.count", i), {27'd0, count_b}, 32'(i + 1));
            chk($sformatf("b_w%0d.full", i), {31'd0, full_b}, (i == 15) ? 32'd1 : 32'd0);
            chk($sformatf("b_w%0d.af", i), {31'd0, almost_full_b}, (i >= 14) ? 32'd1 : 32'd0);
            chk($sformatf("b_w%0d.ae", i), {31'd0, almost_empty_b}, (i == 0) ? 32'd1 : 32'd0);
            chk($sformatf("b_w%0d.rdata", i), {16'd0, rdata_b}, 32'h0000A000);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en_b = 1'b0; rd_en_b = 1'b1;
            chk($sformatf("b_r%0d.rdata", i), {16'd0, rdata_b}, 32'(16'hA000 + i));
            @(posedge clk);
            #1;
            chk($sformatf("b_r%0d.count", i), {27'd0, count_b}, 32'(15 - i));
            chk($sformatf("b_r%0d.empty", i), {31'd0, empty_b}, (i == 15) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        rd_en_b = 1'b0;
        chk("b_end.flags", {30'd0, overflow_b, underflow_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
